// File: rtl/usb_rx_pkt_mem_writer_if.sv
// Bundle of the receive byte stream, packet-RAM write port, descriptor
// handshake and space-release signals around usb_rx_pkt_mem_writer.
// master = the writer itself, slave = its environment.
interface usb_rx_pkt_mem_writer_if #(
  parameter int unsigned ADDR_W = 16
);
  // ULPI receive byte stream
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_sop;
  logic              rx_eop;
  logic              rx_err;
  logic              rx_ready;
  // Packet RAM write port
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  // Packet descriptor towards CPU/DMA
  logic              desc_valid;
  logic              desc_ready;
  logic [ADDR_W-1:0] desc_addr;
  logic [10:0]       desc_len;
  logic              desc_err;
  // Space returned by the consumer
  logic              release_valid;
  logic [10:0]       release_words;
  // Status
  logic [15:0]       drop_cnt;

  modport master (
    input  rx_valid, rx_data, rx_sop, rx_eop, rx_err,
    output rx_ready,
    output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata, mem_clken,
    output desc_valid, desc_addr, desc_len, desc_err,
    input  desc_ready,
    input  release_valid, release_words,
    output drop_cnt
  );

  modport slave (
    output rx_valid, rx_data, rx_sop, rx_eop, rx_err,
    input  rx_ready,
    input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata, mem_clken,
    input  desc_valid, desc_addr, desc_len, desc_err,
    output desc_ready,
    output release_valid, release_words,
    input  drop_cnt
  );
endinterface

// File: rtl/usb_rx_pkt_mem_writer.sv
// Receive packet writer: packs sop/eop framed bytes little-endian into 32-bit
// words, stores them in a circular region of the packet RAM and emits one
// descriptor (start address, length, error) per completed packet. Packets that
// do not fit into the free space are dropped and counted.
module usb_rx_pkt_mem_writer #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned BUF_BASE  = 0,
  parameter int unsigned BUF_WORDS = 1024,
  parameter int unsigned MAX_BYTES = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  usb_rx_pkt_mem_writer_if.master bus
);

  localparam int unsigned       FREE_W     = $clog2(BUF_WORDS + 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BUF_BASE);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BUF_BASE + BUF_WORDS - 1);
  localparam logic [FREE_W-1:0] FREE_FULL  = FREE_W'(BUF_WORDS);
  localparam logic [10:0]       MAX_LEN    = 11'(MAX_BYTES);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StPkt   = 3'd1;
  localparam logic [2:0] StFlush = 3'd2;
  localparam logic [2:0] StDesc  = 3'd3;
  localparam logic [2:0] StDrop  = 3'd4;

  // Control / ring state
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;     // next word to write
  logic [ADDR_W-1:0] start_q, start_d;       // first word of current packet
  logic [FREE_W-1:0] free_q, free_d;         // unused ring words
  logic [FREE_W-1:0] words_q, words_d;       // words written for current packet
  logic [10:0]       cnt_q, cnt_d;           // bytes stored for current packet
  logic [31:0]       word_q, word_d;         // word under assembly
  logic              err_q, err_d;
  logic              trunc_q, trunc_d;
  logic [15:0]       drop_cnt_q, drop_cnt_d;
  // Registered write port
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_data_q, mem_data_d;
  logic [3:0]        mem_be_q, mem_be_d;
  // Registered descriptor
  logic              desc_valid_q, desc_valid_d;
  logic [ADDR_W-1:0] desc_addr_q, desc_addr_d;
  logic [10:0]       desc_len_q, desc_len_d;
  logic              desc_err_q, desc_err_d;

  // Per-byte datapath
  logic              rx_ready;
  logic              accept;
  logic              restart;     // sop inside a packet: abandon and start over
  logic              start_new;
  logic              take;        // byte enters the packing datapath
  logic [ADDR_W-1:0] eff_ptr;
  logic [ADDR_W-1:0] eff_start;
  logic [FREE_W-1:0] eff_free;
  logic [FREE_W-1:0] eff_words;
  logic [10:0]       eff_cnt;
  logic [31:0]       eff_word;
  logic              eff_err;
  logic              eff_trunc;
  logic              store;
  logic [1:0]        lane;
  logic [31:0]       new_word;
  logic [2:0]        nbytes;
  logic [3:0]        be;
  logic              need_write;
  logic [FREE_W-1:0] free_base;
  logic [31:0]       free_sum;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? FIRST_ADDR : a + 1'b1;
  endfunction

  assign rx_ready = (state_q == StIdle) || (state_q == StPkt) || (state_q == StDrop);
  assign accept   = bus.rx_valid && rx_ready;

  // Packing datapath: values a byte works against, with a restart folding in the rewind
  always_comb begin
    restart   = accept && bus.rx_sop && (state_q == StPkt);
    start_new = accept && bus.rx_sop && ((state_q == StIdle) || (state_q == StPkt));
    take      = start_new || (accept && !bus.rx_sop && (state_q == StPkt));
    eff_ptr   = restart ? start_q : wr_ptr_q;
    eff_free  = restart ? free_q + words_q : free_q;
    eff_start = start_new ? eff_ptr : start_q;
    eff_words = start_new ? '0 : words_q;
    eff_cnt   = start_new ? '0 : cnt_q;
    eff_word  = start_new ? '0 : word_q;
    eff_err   = !start_new && err_q;
    eff_trunc = !start_new && trunc_q;

    store    = (eff_cnt < MAX_LEN);
    lane     = eff_cnt[1:0];
    new_word = eff_word;
    if (store) begin
      new_word[{lane, 3'b000} +: 8] = bus.rx_data;
    end
    // Bytes in the word to be written; a truncated packet flushes its pending partial word
    nbytes = store ? ({1'b0, lane} + 3'd1) : {1'b0, lane};
    need_write = take && (store ? ((lane == 2'd3) || bus.rx_eop)
                                : (bus.rx_eop && (lane != 2'd0)));
    case (nbytes)
      3'd1:    be = 4'h1;
      3'd2:    be = 4'h3;
      3'd3:    be = 4'h7;
      default: be = 4'hF;
    endcase
  end

  // Next-state: FSM, ring pointers, free space, write port and descriptor
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    start_d      = start_q;
    words_d      = words_q;
    cnt_d        = cnt_q;
    word_d       = word_q;
    err_d        = err_q;
    trunc_d      = trunc_q;
    drop_cnt_d   = drop_cnt_q;
    mem_write_d  = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    mem_be_d     = mem_be_q;
    desc_valid_d = desc_valid_q;
    desc_addr_d  = desc_addr_q;
    desc_len_d   = desc_len_q;
    desc_err_d   = desc_err_q;
    free_base    = free_q;

    if (take) begin
      if (need_write && (eff_free == '0)) begin
        // No room: rewind to packet start, give back its words, discard to eop
        wr_ptr_d  = eff_start;
        free_base = eff_free + eff_words;
        words_d   = '0;
        cnt_d     = '0;
        word_d    = '0;
        err_d     = 1'b0;
        trunc_d   = 1'b0;
        if (drop_cnt_q != 16'hFFFF) begin
          drop_cnt_d = drop_cnt_q + 16'd1;
        end
        state_d = bus.rx_eop ? StIdle : StDrop;
      end else begin
        start_d = eff_start;
        cnt_d   = store ? eff_cnt + 11'd1 : eff_cnt;
        err_d   = eff_err || (bus.rx_eop && bus.rx_err);
        trunc_d = eff_trunc || !store;
        state_d = bus.rx_eop ? StFlush : StPkt;
        if (need_write) begin
          mem_write_d = 1'b1;
          mem_addr_d  = eff_ptr;
          mem_data_d  = new_word;
          mem_be_d    = be;
          wr_ptr_d    = next_addr(eff_ptr);
          free_base   = eff_free - 1'b1;
          words_d     = eff_words + 1'b1;
          word_d      = '0;
        end else begin
          wr_ptr_d  = eff_ptr;
          free_base = eff_free;
          words_d   = eff_words;
          word_d    = new_word;
        end
      end
    end

    case (state_q)
      StFlush: begin
        // Last word went out this cycle; publish the descriptor next
        state_d      = StDesc;
        desc_valid_d = 1'b1;
        desc_addr_d  = start_q;
        desc_len_d   = cnt_q;
        desc_err_d   = err_q || trunc_q;
      end
      StDesc: begin
        if (desc_valid_q && bus.desc_ready) begin
          desc_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      StDrop: begin
        if (accept && bus.rx_eop) begin
          state_d = StIdle;
        end
      end
      default: ;
    endcase

    // Release and write in one cycle combine; space can never exceed the ring
    free_sum = 32'(free_base) + (bus.release_valid ? 32'(bus.release_words) : 32'd0);
    free_d   = (free_sum > BUF_WORDS) ? FREE_FULL : FREE_W'(free_sum);
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      wr_ptr_q     <= FIRST_ADDR;
      start_q      <= FIRST_ADDR;
      free_q       <= FREE_FULL;
      words_q      <= '0;
      cnt_q        <= '0;
      word_q       <= '0;
      err_q        <= 1'b0;
      trunc_q      <= 1'b0;
      drop_cnt_q   <= '0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      mem_be_q     <= '0;
      desc_valid_q <= 1'b0;
      desc_addr_q  <= '0;
      desc_len_q   <= '0;
      desc_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      start_q      <= start_d;
      free_q       <= free_d;
      words_q      <= words_d;
      cnt_q        <= cnt_d;
      word_q       <= word_d;
      err_q        <= err_d;
      trunc_q      <= trunc_d;
      drop_cnt_q   <= drop_cnt_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      mem_be_q     <= mem_be_d;
      desc_valid_q <= desc_valid_d;
      desc_addr_q  <= desc_addr_d;
      desc_len_q   <= desc_len_d;
      desc_err_q   <= desc_err_d;
    end
  end

  assign bus.rx_ready       = rx_ready;
  assign bus.mem_address    = mem_addr_q;
  assign bus.mem_chipselect = mem_write_q;
  assign bus.mem_write      = mem_write_q;
  assign bus.mem_byteenable = mem_be_q;
  assign bus.mem_writedata  = mem_data_q;
  assign bus.mem_clken      = 1'b1;
  assign bus.desc_valid     = desc_valid_q;
  assign bus.desc_addr      = desc_addr_q;
  assign bus.desc_len       = desc_len_q;
  assign bus.desc_err       = desc_err_q;
  assign bus.drop_cnt       = drop_cnt_q;

endmodule
